// File: rtl/matmul_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : matmul_sequencer
//  Brief    : Operand-feed / pipeline-drain / scratchpad-write sequencer for
//             the matrix-multiply register file, with host access stalling.
//  Revision : 1.0
// ============================================================================
module matmul_sequencer #(
  parameter int DATA_WIDTH = 32,
  parameter int BUS_WIDTH  = 64,
  parameter int ADDR_WIDTH = 32,
  parameter int PIPE_LAT   = 2
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  start_bit_i,
  input  logic [1:0]            n_dim_i,
  input  logic [1:0]            k_dim_i,
  input  logic [1:0]            m_dim_i,
  input  logic                  host_we_i,
  input  logic [ADDR_WIDTH-1:0] host_addr_i,
  output logic [ADDR_WIDTH-1:0] address_a_o,
  output logic [ADDR_WIDTH-1:0] address_b_o,
  output logic [ADDR_WIDTH-1:0] address_c_o,
  output logic                  sp_enable_o,
  output logic                  clear_start_o,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  error_o,
  output logic                  host_stall_o
);

  localparam int MAX_DIM = BUS_WIDTH / DATA_WIDTH;
  localparam int LW      = (MAX_DIM > 1) ? $clog2(MAX_DIM) : 1;
  // Counters hold dimensions up to 4 as well as indices up to MAX_DIM.
  localparam int CW      = ((LW > 3) ? LW : 3) + 1;
  localparam int PW      = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;

  localparam logic [CW-1:0] c_max_dim = CW'(MAX_DIM);
  localparam logic [CW-1:0] c_one     = CW'(1);
  localparam logic [PW-1:0] c_drain_last = PW'(PIPE_LAT - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FEED  = 3'd1,
    S_DRAIN = 3'd2,
    S_WRITE = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t                r_state;
  logic                  r_start_q;
  logic [CW-1:0]         r_n, r_k, r_m;
  logic [CW-1:0]         r_t, r_i, r_j;
  logic [PW-1:0]         r_d;
  logic [ADDR_WIDTH-1:0] r_addr_ab, r_addr_c;
  logic                  r_sp_en, r_clear, r_busy, r_done, r_error;

  logic [CW-1:0] w_n, w_k, w_m, w_j_nxt, w_i_nxt;
  logic          w_start_edge, w_dims_ok, w_row_end, w_last, w_sel;
  logic          w_unused;

  function automatic logic [ADDR_WIDTH-1:0] f_line_addr(input logic [CW-1:0] idx);
    logic [ADDR_WIDTH-1:0] a;
    a = '0;
    a[5 +: LW] = idx[LW-1:0];
    return a;
  endfunction

  function automatic logic [ADDR_WIDTH-1:0] f_elem_addr(input logic [CW-1:0] i,
                                                        input logic [CW-1:0] j);
    logic [ADDR_WIDTH-1:0] a;
    logic [2*LW-1:0]       e;
    e = (2*LW)'(i) * (2*LW)'(MAX_DIM) + (2*LW)'(j);
    a = '0;
    a[5 +: 2*LW] = e;
    return a;
  endfunction

  assign w_start_edge = start_bit_i & ~r_start_q;
  assign w_n          = CW'(n_dim_i) + c_one;
  assign w_k          = CW'(k_dim_i) + c_one;
  assign w_m          = CW'(m_dim_i) + c_one;
  assign w_dims_ok    = (w_n <= c_max_dim) && (w_k <= c_max_dim) && (w_m <= c_max_dim);

  assign w_row_end = (r_j == r_m - c_one);
  assign w_j_nxt   = w_row_end ? '0 : r_j + c_one;
  assign w_i_nxt   = w_row_end ? r_i + c_one : r_i;
  assign w_last    = w_row_end && (r_i == r_n - c_one);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state   <= S_IDLE;
      r_start_q <= 1'b0;
      r_n       <= '0;
      r_k       <= '0;
      r_m       <= '0;
      r_t       <= '0;
      r_i       <= '0;
      r_j       <= '0;
      r_d       <= '0;
      r_addr_ab <= '0;
      r_addr_c  <= '0;
      r_sp_en   <= 1'b0;
      r_clear   <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_error   <= 1'b0;
    end else begin
      r_start_q <= start_bit_i;
      r_addr_ab <= '0;
      r_addr_c  <= '0;
      r_sp_en   <= 1'b0;
      r_clear   <= 1'b0;
      r_done    <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_start_edge) begin
            r_n     <= w_n;
            r_k     <= w_k;
            r_m     <= w_m;
            r_t     <= '0;
            r_busy  <= 1'b1;
            r_error <= ~w_dims_ok;
            if (w_dims_ok) begin
              r_state   <= S_FEED;
              r_addr_ab <= f_line_addr('0);
            end else begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
              r_clear <= 1'b1;
            end
          end
        end
        S_FEED: begin
          if (r_t == r_k - c_one) begin
            r_state <= S_DRAIN;
            r_d     <= '0;
          end else begin
            r_t       <= r_t + c_one;
            r_addr_ab <= f_line_addr(r_t + c_one);
          end
        end
        S_DRAIN: begin
          if (r_d == c_drain_last) begin
            r_state  <= S_WRITE;
            r_i      <= '0;
            r_j      <= '0;
            r_sp_en  <= 1'b1;
            r_addr_c <= f_elem_addr('0, '0);
          end else begin
            r_d <= r_d + PW'(1);
          end
        end
        S_WRITE: begin
          if (w_last) begin
            r_state <= S_DONE;
            r_done  <= 1'b1;
            r_clear <= 1'b1;
          end else begin
            r_i      <= w_i_nxt;
            r_j      <= w_j_nxt;
            r_sp_en  <= 1'b1;
            r_addr_c <= f_elem_addr(w_i_nxt, w_j_nxt);
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  // Only operand A/B and scratchpad windows are guarded; control and flags stay open.
  assign w_sel = (host_addr_i[4:0] == 5'b00100) ||
                 (host_addr_i[4:0] == 5'b01000) ||
                 (host_addr_i[4:0] == 5'b10000);

  assign host_stall_o  = r_busy & w_sel;
  assign address_a_o   = r_addr_ab;
  assign address_b_o   = r_addr_ab;
  assign address_c_o   = r_addr_c;
  assign sp_enable_o   = r_sp_en;
  assign clear_start_o = r_clear;
  assign busy_o        = r_busy;
  assign done_o        = r_done;
  assign error_o       = r_error;

  assign w_unused = &{1'b0, host_we_i, host_addr_i[ADDR_WIDTH-1:5]};

endmodule
`default_nettype wire

// File: tb/tb_matmul_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_matmul_sequencer
//  Brief    : Directed bench with a timeline model of matmul_sequencer.
//  Revision : 1.0
// ============================================================================
module tb_matmul_sequencer;
  localparam int AW = 32;
  localparam int P  = 2;
  localparam int MD = 2;

  logic          clk_i = 1'b0;
  logic          rst_i, start_bit_i, host_we_i;
  logic [1:0]    n_dim_i, k_dim_i, m_dim_i;
  logic [AW-1:0] host_addr_i;
  logic [AW-1:0] address_a_o, address_b_o, address_c_o;
  logic          sp_enable_o, clear_start_o, busy_o, done_o, error_o, host_stall_o;

  always #5 clk_i = ~clk_i;

  matmul_sequencer #(
    .DATA_WIDTH(32), .BUS_WIDTH(64), .ADDR_WIDTH(AW), .PIPE_LAT(P)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i), .start_bit_i(start_bit_i),
    .n_dim_i(n_dim_i), .k_dim_i(k_dim_i), .m_dim_i(m_dim_i),
    .host_we_i(host_we_i), .host_addr_i(host_addr_i),
    .address_a_o(address_a_o), .address_b_o(address_b_o), .address_c_o(address_c_o),
    .sp_enable_o(sp_enable_o), .clear_start_o(clear_start_o), .busy_o(busy_o),
    .done_o(done_o), .error_o(error_o), .host_stall_o(host_stall_o)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int s = 0;
  int mn = 1, mk = 1, mm = 1;
  bit m_run = 0, m_err = 0, m_prev = 0, m_init = 0, m_ok = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int run_len();
    return m_ok ? (mk + P + mn * mm + 1) : 1;
  endfunction

  // Timeline model: a run is described by its start cycle and latched dimensions.
  always @(posedge clk_i) begin
    cyc = cyc + 1;
    if (rst_i) begin
      m_run = 0; m_err = 0; m_prev = 0; m_init = 1;
    end else begin
      if ((!m_run || (cyc - 1 - s) > run_len()) && start_bit_i && !m_prev) begin
        mn = int'(n_dim_i) + 1;
        mk = int'(k_dim_i) + 1;
        mm = int'(m_dim_i) + 1;
        m_ok  = (mn <= MD) && (mk <= MD) && (mm <= MD);
        m_err = !m_ok;
        m_run = 1;
        s     = cyc - 1;
      end
      m_prev = start_bit_i;
    end
  end

  always @(negedge clk_i) begin
    int o, w, len;
    logic [31:0] ea, ec;
    logic esp, edn, ebusy, est;
    if (m_init) begin
      o = cyc - s;
      len = run_len();
      ea = '0; ec = '0; esp = 0; edn = 0; ebusy = 0;
      if (m_run && o >= 1 && o <= len) begin
        ebusy = 1;
        edn   = (o == len);
        if (m_ok) begin
          if (o <= mk) ea = 32'(o - 1) << 5;
          w = o - mk - P - 1;
          if (w >= 0 && w < mn * mm) begin
            esp = 1;
            ec  = 32'((w / mm) * MD + (w % mm)) << 5;
          end
        end
      end
      est = ebusy && (host_addr_i[4:0] == 5'h04 || host_addr_i[4:0] == 5'h08 ||
                      host_addr_i[4:0] == 5'h10);
      chk("m_addr_a", address_a_o, ea);
      chk("m_addr_b", address_b_o, ea);
      chk("m_addr_c", address_c_o, ec);
      chk("m_sp_en", {31'd0, sp_enable_o}, {31'd0, esp});
      chk("m_done", {31'd0, done_o}, {31'd0, edn});
      chk("m_clear", {31'd0, clear_start_o}, {31'd0, edn});
      chk("m_busy", {31'd0, busy_o}, {31'd0, ebusy});
      chk("m_error", {31'd0, error_o}, {31'd0, m_err});
      chk("m_stall", {31'd0, host_stall_o}, {31'd0, est});
    end
  end

  task automatic step(input int n = 1);
    repeat (n) @(posedge clk_i);
    #1;
  endtask

  task automatic set_dims(input logic [1:0] n, input logic [1:0] k, input logic [1:0] m);
    n_dim_i = n; k_dim_i = k; m_dim_i = m;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    logic [AW-1:0] addrs [4];
    addrs[0] = 32'h04; addrs[1] = 32'h0C; addrs[2] = 32'h10; addrs[3] = 32'h08;
    rst_i = 1; start_bit_i = 0; host_we_i = 0; host_addr_i = '0;
    set_dims(2'd1, 2'd1, 2'd1);
    step(2);
    rst_i = 0;
    chk("rst_busy", {31'd0, busy_o}, 32'd0);
    chk("rst_error", {31'd0, error_o}, 32'd0);
    chk("rst_addr_a", address_a_o, 32'd0);

    // 2x2x2 run, start level held through completion.
    start_bit_i = 1;
    step();
    chk("t1_c1_a", address_a_o, 32'h00);
    chk("t1_c1_busy", {31'd0, busy_o}, 32'd1);
    step();
    chk("t1_c2_a", address_a_o, 32'h20);
    chk("t1_c2_b", address_b_o, 32'h20);
    step(3);
    chk("t1_c5_c", address_c_o, 32'h00);
    chk("t1_c5_sp", {31'd0, sp_enable_o}, 32'd1);
    host_addr_i = 32'h04; #1 chk("t1_stall_04", {31'd0, host_stall_o}, 32'd1);
    host_addr_i = 32'h10; #1 chk("t1_stall_10", {31'd0, host_stall_o}, 32'd1);
    host_addr_i = 32'h0C; #1 chk("t1_stall_0c", {31'd0, host_stall_o}, 32'd0);
    host_addr_i = '0;
    step();
    chk("t1_c6_c", address_c_o, 32'h20);
    step();
    chk("t1_c7_c", address_c_o, 32'h40);
    step();
    chk("t1_c8_c", address_c_o, 32'h60);
    step();
    chk("t1_c9_done", {31'd0, done_o}, 32'd1);
    chk("t1_c9_clear", {31'd0, clear_start_o}, 32'd1);
    chk("t1_c9_busy", {31'd0, busy_o}, 32'd1);
    step(5);
    chk("t1_no_retrig", {31'd0, busy_o}, 32'd0);
    host_addr_i = 32'h04; #1 chk("idle_stall_04", {31'd0, host_stall_o}, 32'd0);
    host_addr_i = 32'h10; #1 chk("idle_stall_10", {31'd0, host_stall_o}, 32'd0);
    host_addr_i = 32'h0C; #1 chk("idle_stall_0c", {31'd0, host_stall_o}, 32'd0);
    host_addr_i = '0;

    // N=1, K=2, M=1.
    start_bit_i = 0;
    step();
    set_dims(2'd0, 2'd1, 2'd0);
    start_bit_i = 1;
    step(5);
    chk("t2_c5_c", address_c_o, 32'h00);
    chk("t2_c5_sp", {31'd0, sp_enable_o}, 32'd1);
    step();
    chk("t2_c6_done", {31'd0, done_o}, 32'd1);
    step();

    // Oversized dimension, then minimum-size run clears the error.
    start_bit_i = 0;
    step();
    set_dims(2'd3, 2'd1, 2'd1);
    start_bit_i = 1;
    step();
    chk("t3_err_done", {31'd0, done_o}, 32'd1);
    chk("t3_err_clear", {31'd0, clear_start_o}, 32'd1);
    chk("t3_err_flag", {31'd0, error_o}, 32'd1);
    step(2);
    chk("t3_err_sticky", {31'd0, error_o}, 32'd1);
    start_bit_i = 0;
    step();
    set_dims(2'd0, 2'd0, 2'd0);
    start_bit_i = 1;
    step();
    chk("t3_err_cleared", {31'd0, error_o}, 32'd0);
    step(3);
    chk("t3_min_sp", {31'd0, sp_enable_o}, 32'd1);
    step();
    chk("t3_min_done", {31'd0, done_o}, 32'd1);
    step();

    // Reset in cycle 6 of a 2x2x2 run; dimension changes mid-run are ignored.
    start_bit_i = 0;
    step();
    set_dims(2'd1, 2'd1, 2'd1);
    start_bit_i = 1;
    step();
    set_dims(2'd3, 2'd3, 2'd3);
    step(5);
    rst_i = 1; start_bit_i = 0;
    step();
    rst_i = 0;
    chk("t4_rst_busy", {31'd0, busy_o}, 32'd0);
    chk("t4_rst_sp", {31'd0, sp_enable_o}, 32'd0);
    chk("t4_rst_c", address_c_o, 32'd0);
    chk("t4_rst_done", {31'd0, done_o}, 32'd0);
    set_dims(2'd1, 2'd1, 2'd1);
    start_bit_i = 1;
    for (int c = 1; c <= 9; c++) begin
      step();
      host_addr_i = addrs[c % 4];
    end
    chk("t4_fresh_done", {31'd0, done_o}, 32'd1);
    host_addr_i = '0;
    step(2);

    // Start edge coinciding with reset is dropped.
    start_bit_i = 0;
    step();
    start_bit_i = 1; rst_i = 1;
    step();
    rst_i = 0; start_bit_i = 0;
    chk("t5_rst_start", {31'd0, busy_o}, 32'd0);
    step();
    chk("t5_no_run", {31'd0, busy_o}, 32'd0);
    step(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/matmul_sequencer.md
# matmul_sequencer

Sequencer for the matrix-multiply register file and its processing datapath. On a start request it does three things in order:
- walks the operand-A/B line addresses to feed the datapath;
- waits out the datapath pipeline latency;
- steps the scratchpad element address with write enable asserted so each result element lands in SP.

While an operation runs it stalls host bus accesses to operands and scratchpad, and it clears the start bit in the control register when done.

## Interface
Parameters:
- DATA_WIDTH, 32, element width
- BUS_WIDTH, 64, bus width; MAX_DIM = BUS_WIDTH/DATA_WIDTH; LW = max(1,$clog2(MAX_DIM))
- ADDR_WIDTH, 32, address width
- PIPE_LAT, 2, datapath latency in cycles from the last operand line to the first valid result (≥1)

Ports (clock and reset first):
- clk_i  in  1  clock; all logic is rising-edge
- rst_i  in  1  reset: one clock; reset is synchronous and active-high
- start_bit_i  in  1  start bit from the control register (level)
- n_dim_i, k_dim_i, m_dim_i  in  2 each  dimension fields; actual dimension = field+1
- host_we_i  in  1  host bus write/read strobe
- host_addr_i  in  ADDR_WIDTH  host bus address
- address_a_o, address_b_o  out  ADDR_WIDTH  operand line address; line index at bits [5+:LW], all other bits 0
- address_c_o  out  ADDR_WIDTH  SP element address; index i*MAX_DIM+j at bits [5+:2*LW], all other bits 0
- sp_enable_o  out  1  SP/flags write enable to the register file
- clear_start_o  out  1  one-cycle pulse that clears the start bit
- busy_o  out  1  high in every state except IDLE
- done_o  out  1  one-cycle completion pulse
- error_o  out  1  sticky dimension error; cleared on the next accepted start
- host_stall_o  out  1  host access blocked this cycle

## Operation
- Start detection: a registered copy of start_bit_i gives a rising-edge detect. A rising edge seen in IDLE is accepted.
  - A level held high after DONE does not retrigger.
  - Edges that arrive outside IDLE are ignored.
- On acceptance, N, K and M are latched from the dimension inputs.
- If any of N, K, M exceeds MAX_DIM, the block goes straight to DONE and sets error_o. No address stepping and no sp_enable_o in this case.
- FSM states and transitions:
  - IDLE → FEED: on an accepted, valid start; t=0.
  - FEED: address_a_o and address_b_o line index = t; t increments each cycle. After K cycles (t=K-1) → DRAIN.
  - DRAIN: counts PIPE_LAT cycles → WRITE; i=j=0.
  - WRITE: sp_enable_o=1; address_c_o index = i*MAX_DIM+j. j increments each cycle; at j=M-1, j wraps to 0 and i increments. After the element (N-1, M-1) → DONE. N*M cycles in total.
  - DONE: done_o=1 and clear_start_o=1 for one cycle → IDLE.
- Outside FEED, address_a_o and address_b_o are 0. Outside WRITE, address_c_o is 0 and sp_enable_o is 0.
- host_stall_o = busy_o AND host_addr_i[4:0] ∈ {5'b00100, 5'b01000, 5'b10000} (OPERAND_A, OPERAND_B, SP).
  - CONTROL (00000) and FLAGS (01100) are never stalled.
  - host_we_i does not affect the stall decision; it is carried for the bus-side mux.
- Dimension inputs are ignored once latched; changes mid-operation have no effect.

## Timing
- Reset: state=IDLE, all counters 0, start-edge register 0. All outputs are 0, including error_o.
- Reset asserted mid-operation aborts in one cycle: IDLE and all outputs 0, with no done_o or clear_start_o pulse.
- All outputs are registered-state decodes, except host_stall_o, which is combinational from host_addr_i and state.
- Valid operation, start edge sampled at cycle 0:
  - FEED occupies cycles 1..K.
  - DRAIN occupies K+1..K+PIPE_LAT.
  - WRITE occupies K+PIPE_LAT+1..K+PIPE_LAT+N*M.
  - DONE is the next cycle.
  - Total latency from start to done_o = K+PIPE_LAT+N*M+1 cycles.
- Error path: done_o, clear_start_o and error_o are all high at cycle 1.
- Start edge and rst_i in the same cycle: reset wins and the start is dropped.
- Minimum dimensions (fields 0,0,0): FEED 1 cycle, WRITE 1 cycle, element 0.

## Test plan
- Reset, then start_bit_i 0→1 with N=K=M=2, PIPE_LAT=2 →
  - address_a_o = 0x00, 0x20 in cycles 1-2;
  - DRAIN in cycles 3-4;
  - address_c_o = 0x00, 0x20, 0x40, 0x60 with sp_enable_o=1 in cycles 5-8;
  - done_o and clear_start_o high in cycle 9; busy_o high in cycles 1-9.
- N=1, K=2, M=1 → address_c_o = 0x00 only, single WRITE cycle; done_o at cycle 2+2+1+1=6.
- Dimension field 3 (dim 4 > MAX_DIM=2) → done_o, clear_start_o and error_o high at cycle 1, sp_enable_o never high. A following valid start clears error_o.
- start_bit_i held high across DONE and into IDLE → no second run. Toggle it low and then high → a second run starts.
- During WRITE, host_addr_i = 0x04, 0x10, 0x0C → host_stall_o = 1, 1, 0. In IDLE, all three give 0.
- rst_i pulsed in cycle 6 of a 2×2×2 run → every output 0 at cycle 7, no done_o. A fresh start afterwards completes normally.
